// File: rtl/serv_rf_ram_dbg.sv
// Word-wide RF SRAM for the bit-serial core, with a 32-bit debug port that moves
// whole registers beat by beat through whichever RAM port the core leaves idle.
module serv_rf_ram_dbg #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int rf_count = 32,
    parameter int raw      = $clog2(rf_count + csr_regs),
    parameter int l2w      = $clog2(width),
    parameter int aw       = 5 + raw - l2w
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [raw-1:0]   i_dbg_reg,
    input  logic [31:0]      i_dbg_wdata,
    output logic             o_dbg_busy,
    output logic             o_dbg_ack,
    output logic [31:0]      o_dbg_rdata
);
    localparam int bw    = 5 - l2w;
    localparam int beats = 32 / width;
    localparam logic [bw:0] last_cnt = (bw + 1)'(beats);

    typedef enum logic [2:0] {IDLE, WR, RD, RDL, ACK} state_t;

    logic [width-1:0] mem [0:(2**aw)-1];
    logic [width-1:0] ram_q_reg;

    state_t           state_reg, state_next;
    logic [bw:0]      cnt_reg, cnt_next;
    logic [raw-1:0]   reg_reg;
    logic [31:0]      wdata_reg;
    logic             pend_reg;
    logic [bw-1:0]    pend_beat_reg;
    logic [width-1:0] rbuf_reg [beats];
    logic [width-1:0] wbeat [beats];
    logic [31:0]      rbuf_flat;
    logic [31:0]      dbg_rdata_reg;
    logic             core_valid_reg;
    logic [width-1:0] core_hold_reg;

    logic             load, commit, dbg_wen, dbg_ren, ack;
    logic [aw-1:0]    dbg_addr;
    logic             ram_wen, ram_ren;
    logic [aw-1:0]    ram_waddr, ram_raddr;
    logic [width-1:0] ram_wdata;

    generate
        for (genvar gi = 0; gi < beats; gi++) begin : g_beat
            assign wbeat[gi]                     = wdata_reg[gi*width +: width];
            assign rbuf_flat[gi*width +: width]  = rbuf_reg[gi];
        end
    endgenerate

    // Debug beats only ever take a port the core is not using this cycle.
    assign dbg_addr  = {reg_reg, cnt_reg[bw-1:0]};
    assign ram_wen   = i_wen | (dbg_wen & ~i_rst);
    assign ram_waddr = i_wen ? i_waddr : dbg_addr;
    assign ram_wdata = i_wen ? i_wdata : wbeat[cnt_reg[bw-1:0]];
    assign ram_ren   = i_ren | dbg_ren;
    assign ram_raddr = i_ren ? i_raddr : dbg_addr;

    always_ff @(posedge i_clk) begin
        if (ram_wen)
            mem[ram_waddr] <= ram_wdata;
        if (ram_ren)
            ram_q_reg <= mem[ram_raddr];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        commit     = 1'b0;
        dbg_wen    = 1'b0;
        dbg_ren    = 1'b0;
        ack        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_dbg_req) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = i_dbg_we ? WR : RD;
                end
            end
            WR: begin
                if (cnt_reg == last_cnt) begin
                    state_next = ACK;
                end else if (!i_wen) begin
                    dbg_wen  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RD: begin
                if (cnt_reg == last_cnt) begin
                    state_next = RDL;
                end else if (!i_ren) begin
                    dbg_ren  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RDL: begin
                commit     = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                ack        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            pend_reg       <= 1'b0;
            dbg_rdata_reg  <= '0;
            core_valid_reg <= 1'b0;
            core_hold_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_reg       <= dbg_ren;
            core_valid_reg <= i_ren;
            if (core_valid_reg)
                core_hold_reg <= ram_q_reg;
            // Result is published as a whole word so partial reads never show.
            if (commit)
                dbg_rdata_reg <= rbuf_flat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (load) begin
            reg_reg   <= i_dbg_reg;
            wdata_reg <= i_dbg_wdata;
        end
        pend_beat_reg <= cnt_reg[bw-1:0];
        if (pend_reg)
            rbuf_reg[pend_beat_reg] <= ram_q_reg;
    end

    // Core data is live the cycle after a core read and held otherwise.
    assign o_rdata     = core_valid_reg ? ram_q_reg : core_hold_reg;
    assign o_dbg_busy  = (state_reg != IDLE);
    assign o_dbg_ack   = ack;
    assign o_dbg_rdata = dbg_rdata_reg;
endmodule
